// File: rtl/adder_share_sched_if.sv
// Requester/result bus of the shared limb adder. Requesters and the result
// consumer sit on the master side; the scheduler is the slave.
interface adder_share_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_cin;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_cout;
  logic        res_last;
  logic        res_id;
  logic        busy;

  modport master (
    output req_valid, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_last, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_last, res_id, busy
  );
endinterface

// File: rtl/adder_share_sched.sv
// Time-shares one 32-bit adder between two requesters. Each operation is
// WORDS limbs, LS limb first, with the carry chained through a register.
module adder_share_sched #(
  parameter int unsigned WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adder_share_sched_if.slave        bus
);

  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned LAST  = WORDS - 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_grant;
  logic               w_next_grant;
  logic               r_rr;
  logic               w_next_rr;
  logic [1:0]         w_req_ready;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_res_valid;
  logic [31:0]        r_res_sum;
  logic               r_res_cout;
  logic               r_res_last;
  logic               r_res_id;

  logic               w_slot_free;
  logic               w_acc;
  logic               w_last;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic               w_cin;
  logic [32:0]        w_sum;

  // Limb operand select, carry source and the single shared adder
  assign w_slot_free = !r_res_valid || bus.res_ready;
  assign w_acc       = (r_state == ST_BUSY) && w_slot_free && bus.req_valid[r_grant];
  assign w_last      = (r_cnt == CNT_W'(LAST));
  assign w_a         = r_grant ? bus.req_a[63:32] : bus.req_a[31:0];
  assign w_b         = r_grant ? bus.req_b[63:32] : bus.req_b[31:0];
  assign w_cin       = (r_cnt == '0) ? bus.req_cin[r_grant] : r_carry;
  assign w_sum       = 33'(w_a) + 33'(w_b) + 33'(w_cin);

  // State, grant and round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_rr    <= w_next_rr;
    end
  end

  // Arbitration in IDLE; grant is locked in BUSY until the last limb
  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    w_next_rr    = r_rr;
    w_req_ready  = 2'b00;
    unique case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          w_next_grant = (bus.req_valid == 2'b11) ? r_rr : bus.req_valid[1];
          w_next_rr    = ~w_next_grant;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_slot_free) begin
          w_req_ready[r_grant] = 1'b1;
        end
        if (w_acc && w_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Limb counter and inter-limb carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_acc) begin
      if (w_last) begin
        r_cnt   <= '0;
        r_carry <= 1'b0;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_carry <= w_sum[32];
      end
    end
  end

  // Single-entry result register: load on accepted limb, clear on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_id    <= 1'b0;
    end else if (w_acc) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum[31:0];
      r_res_cout  <= w_sum[32];
      r_res_last  <= w_last;
      r_res_id    <= r_grant;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_cout  = r_res_cout;
  assign bus.res_last  = r_res_last;
  assign bus.res_id    = r_res_id;
  assign bus.busy      = (r_state == ST_BUSY);

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed bench for adder_share_sched with WORDS=2.
module tb_adder_share_sched;

  logic clk;
  logic rst_n;

  adder_share_sched_if bus ();

  adder_share_sched #(.WORDS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef logic [34:0] res_t;   // {sum, cout, last, id}

  typedef struct {
    int          r;
    logic [31:0] a0, b0, a1, b1;
    logic        cin;
    res_t        e0, e1;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  res_t rq[$];
  bit   ready_both = 0;
  vec_t vecs[4];

  function automatic res_t mk(input logic [31:0] s, input logic c, input logic l, input logic id);
    return {s, c, l, id};
  endfunction

  // Result capture and one-hot ready watch, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready)
      rq.push_back({bus.res_sum, bus.res_cout, bus.res_last, bus.res_id});
    if (bus.req_ready == 2'b11) ready_both = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = 2'b00;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rq.delete();
  endtask

  task automatic send_limb(input int r, input logic [31:0] a, input logic [31:0] b, input logic cin);
    bit ok = 0;
    if (r == 0) begin
      bus.req_a[31:0] = a; bus.req_b[31:0] = b; bus.req_cin[0] = cin;
    end else begin
      bus.req_a[63:32] = a; bus.req_b[63:32] = b; bus.req_cin[1] = cin;
    end
    bus.req_valid[r] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      total++; bad++;
      $display("FAIL send_limb timeout req=%0d got=not_accepted exp=accepted", r);
    end
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 200 && rq.size() < n; i++) @(negedge clk);
    if (rq.size() < n) begin
      total++; bad++;
      $display("FAIL wait_results got=%0d exp=%0d", rq.size(), n);
    end
  endtask

  function automatic res_t rq_at(input int i);
    if (i < rq.size()) return rq[i];
    return '1;
  endfunction

  initial begin
    vecs[0] = '{0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0,
                mk(32'h0, 1'b1, 1'b0, 1'b0), mk(32'h1, 1'b0, 1'b1, 1'b0)};
    vecs[1] = '{1, 32'h7, 32'h8, 32'h0, 32'h0, 1'b1,
                mk(32'h10, 1'b0, 1'b0, 1'b1), mk(32'h0, 1'b0, 1'b1, 1'b1)};
    vecs[2] = '{0, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1,
                mk(32'h1, 1'b1, 1'b0, 1'b0), mk(32'h0, 1'b1, 1'b1, 1'b0)};
    vecs[3] = '{1, 32'h1234_5678, 32'h1111_1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                mk(32'h2345_6789, 1'b0, 1'b0, 1'b1), mk(32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1)};

    // Reset values
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = 2'b00;
    bus.res_ready = 1'b1;
    #2;
    check("reset_outputs",
          64'({bus.req_ready, bus.res_valid, bus.res_sum, bus.res_cout, bus.res_last, bus.res_id, bus.busy}),
          64'h0);
    do_reset();

    // Table of single-requester two-limb operations
    for (int i = 0; i < 4; i++) begin
      rq.delete();
      send_limb(vecs[i].r, vecs[i].a0, vecs[i].b0, vecs[i].cin);
      send_limb(vecs[i].r, vecs[i].a1, vecs[i].b1, 1'b0);
      wait_results(2);
      check($sformatf("vec%0d_limb0", i), 64'(rq_at(0)), 64'(vecs[i].e0));
      check($sformatf("vec%0d_limb1", i), 64'(rq_at(1)), 64'(vecs[i].e1));
    end

    // Both requesters held valid: round-robin alternates whole operations
    do_reset();
    ready_both = 0;
    bus.req_a = {32'd2, 32'd1};
    bus.req_b = '0;
    bus.req_valid = 2'b11;
    wait_results(8);
    bus.req_valid = 2'b00;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      logic exp_id;
      exp_id = ((i / 2) % 2) != 0;
      check($sformatf("rr_id%0d", i), 64'(rq_at(i) & 35'h1), 64'(exp_id));
    end
    check("rr_ready_onehot", 64'(ready_both), 64'd0);

    // Result back-pressure: result held and no limb accepted while stalled
    do_reset();
    bus.res_ready = 1'b0;
    bus.req_a[31:0] = 32'd5;
    bus.req_b[31:0] = 32'd6;
    bus.req_valid[0] = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.req_ready[0]) begin ok = 1; break; end
      end
      check("stall_first_accept", 64'(ok), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.req_a[31:0] = 32'd1;
    bus.req_b[31:0] = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", i),
            64'({bus.res_valid, bus.res_sum, bus.res_cout, bus.req_ready}),
            64'({1'b1, 32'd11, 1'b0, 2'b00}));
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    wait_results(2);
    repeat (3) @(posedge clk);
    check("stall_count", 64'(rq.size()), 64'd2);
    check("stall_res0", 64'(rq_at(0)), 64'(mk(32'd11, 1'b0, 1'b0, 1'b0)));
    check("stall_res1", 64'(rq_at(1)), 64'(mk(32'd3, 1'b0, 1'b1, 1'b0)));

    // Reset in the middle of a carry-generating operation
    do_reset();
    send_limb(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midop_reset_outputs",
          64'({bus.req_ready, bus.res_valid, bus.res_sum, bus.res_cout, bus.res_last, bus.res_id, bus.busy}),
          64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("midop_no_partial", 64'(rq.size()), 64'd0);
    rq.delete();
    send_limb(0, 32'h1, 32'h1, 1'b0);
    send_limb(0, 32'h0, 32'h0, 1'b0);
    wait_results(2);
    check("post_reset_limb0", 64'(rq_at(0)), 64'(mk(32'h2, 1'b0, 1'b0, 1'b0)));
    check("post_reset_limb1", 64'(rq_at(1)), 64'(mk(32'h0, 1'b0, 1'b1, 1'b0)));

    // Requester 0 pauses mid-operation; requester 1 must wait for it
    do_reset();
    fork
      begin
        send_limb(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check($sformatf("gap%0d", i), 64'({bus.busy, bus.req_ready[1]}), 64'({1'b1, 1'b0}));
        end
        @(posedge clk);
        #1;
        send_limb(0, 32'h1, 32'h2, 1'b0);
      end
      begin
        send_limb(1, 32'h9, 32'h0, 1'b0);
        send_limb(1, 32'h9, 32'h0, 1'b0);
      end
    join
    wait_results(4);
    check("gap_res0", 64'(rq_at(0)), 64'(mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0)));
    check("gap_res1", 64'(rq_at(1)), 64'(mk(32'h4, 1'b0, 1'b1, 1'b0)));
    check("gap_res2", 64'(rq_at(2)), 64'(mk(32'h9, 1'b0, 1'b0, 1'b1)));
    check("gap_res3", 64'(rq_at(3)), 64'(mk(32'h9, 1'b0, 1'b1, 1'b1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
